// File: rtl/operand_serializer_if.sv
// Handshake and bit-stream bundle between an operand source, the
// operand_serializer and a downstream bit-serial adder.
//   start, op_a, op_b  : source -> serializer (request and operand pair)
//   ready              : serializer is idle and can take a request
//   add_clr            : one-cycle clear for the adder's carry state
//   a, b               : current operand bits, LSB first
//   bit_valid          : a/b carry a valid operand bit
//   last_bit           : the current bit is the MSB
//   done               : one-cycle pulse after the MSB was presented
interface operand_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             add_clr;
  logic             a;
  logic             b;
  logic             bit_valid;
  logic             last_bit;
  logic             done;

  modport master (
    output start, op_a, op_b,
    input  ready, add_clr, a, b, bit_valid, last_bit, done
  );

  modport slave (
    input  start, op_a, op_b,
    output ready, add_clr, a, b, bit_valid, last_bit, done
  );
endinterface

// File: rtl/operand_serializer.sv
// Serializes an operand pair LSB first into a bit-serial adder.
// Sequence per request: one CLR cycle (add_clr), WIDTH SHIFT cycles
// (bit_valid, last_bit on the MSB), one DONE cycle (done), back to IDLE.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; returns to IDLE and clears all state
//   bus   : operand_serializer_if slave (start/op_a/op_b in, ready and
//           adder-side bit stream out)
// Every output is a flop; nothing from an input reaches an output
// combinationally.
module operand_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  operand_serializer_if.slave  bus
);

  localparam int unsigned     IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_sa, r_sb, w_sa, w_sb;
  logic [IDXW-1:0]  r_idx, w_idx;

  logic r_ready, r_add_clr, r_a, r_b, r_bit_valid, r_last_bit, r_done;
  logic w_ready, w_add_clr, w_a, w_b, w_bit_valid, w_last_bit, w_done;

  always_comb begin
    w_state = r_state;
    w_sa    = r_sa;
    w_sb    = r_sb;
    w_idx   = r_idx;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_sa    = bus.op_a;
          w_sb    = bus.op_b;
          w_state = S_CLR;
        end
      end
      S_CLR: begin
        w_idx   = '0;
        w_state = S_SHIFT;
      end
      S_SHIFT: begin
        w_sa = r_sa >> 1;
        w_sb = r_sb >> 1;
        if (r_idx == LAST_IDX) begin
          w_idx   = '0;
          w_state = S_DONE;
        end else begin
          w_idx = r_idx + IDXW'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and next shift-register
  // contents and then registered, so each output flop shows the value
  // belonging to the state the FSM is in during that cycle.
  always_comb begin
    w_ready     = (w_state == S_IDLE);
    w_add_clr   = (w_state == S_CLR);
    w_bit_valid = (w_state == S_SHIFT);
    w_a         = (w_state == S_SHIFT) && w_sa[0];
    w_b         = (w_state == S_SHIFT) && w_sb[0];
    w_last_bit  = (w_state == S_SHIFT) && (w_idx == LAST_IDX);
    w_done      = (w_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_idx       <= '0;
      r_ready     <= 1'b1;
      r_add_clr   <= 1'b0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_bit_valid <= 1'b0;
      r_last_bit  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sa        <= w_sa;
      r_sb        <= w_sb;
      r_idx       <= w_idx;
      r_ready     <= w_ready;
      r_add_clr   <= w_add_clr;
      r_a         <= w_a;
      r_b         <= w_b;
      r_bit_valid <= w_bit_valid;
      r_last_bit  <= w_last_bit;
      r_done      <= w_done;
    end
  end

  assign bus.ready     = r_ready;
  assign bus.add_clr   = r_add_clr;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.bit_valid = r_bit_valid;
  assign bus.last_bit  = r_last_bit;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_operand_serializer.sv
`timescale 1ns/1ps
module tb_operand_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_serializer_if #(.WIDTH(8)) bus8 ();
  operand_serializer_if #(.WIDTH(1)) bus1 ();

  operand_serializer #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  operand_serializer #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  // Expected bit records for the 8-bit instance: {a, b, last_bit}
  logic [2:0] exp_q[$];
  logic       mon_en = 1'b0;

  // Scoreboard: every bit the 8-bit serializer presents is popped and compared;
  // outside bit_valid the adder inputs must stay quiet.
  always @(negedge clk) begin
    logic [2:0] e;
    logic [2:0] obs;
    if (mon_en) begin
      obs = {bus8.a, bus8.b, bus8.last_bit};
      if (bus8.bit_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra_bit: got bit_valid=1 {a,b,last}=%b, required no bit", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_err++;
            $display("FAIL sb_bit: got {a,b,last}=%b required %b at %0t", obs, e, $time);
          end
        end
      end else begin
        n_cmp++;
        if (obs !== 3'b000 || bus8.bit_valid !== 1'b0) begin
          n_err++;
          $display("FAIL sb_idle_bits: got {a,b,last}=%b valid=%b required 000/0 at %0t",
                   obs, bus8.bit_valid, $time);
        end
      end
    end
  end

  task automatic push_bits(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({a[i], b[i], (i == 7)});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus8.start = 1'b1; bus8.op_a = 8'hFF; bus8.op_b = 8'hFF;
    bus1.start = 1'b1; bus1.op_a = 1'b1;  bus1.op_b = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus8.ready, bus8.add_clr, bus8.a, bus8.b, bus8.bit_valid, bus8.last_bit, bus8.done} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_outs8: got %b required 1000000",
               {bus8.ready, bus8.add_clr, bus8.a, bus8.b, bus8.bit_valid, bus8.last_bit, bus8.done});
    end
    n_cmp++;
    if ({bus1.ready, bus1.add_clr, bus1.a, bus1.b, bus1.bit_valid, bus1.last_bit, bus1.done} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_outs1: got %b required 1000000",
               {bus1.ready, bus1.add_clr, bus1.a, bus1.b, bus1.bit_valid, bus1.last_bit, bus1.done});
    end
    reset = 1'b0;
    bus8.start = 1'b0; bus1.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus8.ready !== 1'b1 || bus8.add_clr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_accept: got ready=%b add_clr=%b required 1/0", bus8.ready, bus8.add_clr);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int clr_n = 0;
    int bits = 0;
    int last_at = -1;
    int done_at = -1;
    push_bits(8'hA5, 8'h3C, 8);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op_a = 8'hA5; bus8.op_b = 8'h3C;
    @(negedge clk);
    bus8.start = 1'b0; bus8.op_a = 8'h00; bus8.op_b = 8'hFF;
    n_cmp++;
    if (bus8.add_clr !== 1'b1 || bus8.ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_clr: got add_clr=%b ready=%b required 1/0", bus8.add_clr, bus8.ready);
    end
    for (int cyc = 1; cyc <= 12 && done_at < 0; cyc++) begin
      @(negedge clk);
      if (bus8.add_clr === 1'b1) clr_n++;
      if (bus8.bit_valid === 1'b1) bits++;
      if (bus8.last_bit === 1'b1) last_at = cyc;
      if (bus8.done === 1'b1) done_at = cyc;
    end
    n_cmp++;
    if (bits != 8) begin n_err++; $display("FAIL basic_bits: got %0d required 8", bits); end
    n_cmp++;
    if (last_at != 8) begin n_err++; $display("FAIL basic_last_cycle: got %0d required 8", last_at); end
    n_cmp++;
    if (done_at != 9) begin n_err++; $display("FAIL basic_done_cycle: got %0d required 9", done_at); end
    n_cmp++;
    if (clr_n != 0) begin n_err++; $display("FAIL basic_extra_clr: got %0d required 0", clr_n); end
    @(negedge clk);
    n_cmp++;
    if (bus8.ready !== 1'b1 || bus8.done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_ready_back: got ready=%b done=%b required 1/0", bus8.ready, bus8.done);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_sb_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_ignore_start();
    int clr_n = 0;
    int ready_hi = 0;
    int done_at = -1;
    push_bits(8'h5A, 8'hC3, 8);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op_a = 8'h5A; bus8.op_b = 8'hC3;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int cyc = 1; cyc <= 12 && done_at < 0; cyc++) begin
      @(negedge clk);
      if (bus8.add_clr === 1'b1) clr_n++;
      if (bus8.ready !== 1'b0) ready_hi++;
      if (bus8.done === 1'b1) done_at = cyc;
      if (cyc == 3) begin bus8.start = 1'b1; bus8.op_a = 8'h00; bus8.op_b = 8'hFF; end
      if (cyc == 6) bus8.start = 1'b0;
    end
    n_cmp++;
    if (clr_n != 0) begin n_err++; $display("FAIL ign_second_clr: got %0d required 0", clr_n); end
    n_cmp++;
    if (ready_hi != 0) begin n_err++; $display("FAIL ign_ready_busy: got %0d cycles required 0", ready_hi); end
    n_cmp++;
    if (done_at != 9) begin n_err++; $display("FAIL ign_done_cycle: got %0d required 9", done_at); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus8.add_clr !== 1'b0 || bus8.ready !== 1'b1) begin
      n_err++;
      $display("FAIL ign_not_queued: got add_clr=%b ready=%b required 0/1", bus8.add_clr, bus8.ready);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL ign_sb_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    int valid_n = 0;
    int clr_n = 0;
    push_bits(8'h96, 8'h69, 4);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op_a = 8'h96; bus8.op_b = 8'h69;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus8.ready, bus8.add_clr, bus8.a, bus8.b, bus8.bit_valid, bus8.last_bit, bus8.done} !== 7'b1000000) begin
      n_err++;
      $display("FAIL rstmid_outs: got %b required 1000000",
               {bus8.ready, bus8.add_clr, bus8.a, bus8.b, bus8.bit_valid, bus8.last_bit, bus8.done});
    end
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done !== 1'b0) done_n++;
      if (bus8.bit_valid !== 1'b0) valid_n++;
      if (bus8.add_clr !== 1'b0) clr_n++;
    end
    n_cmp++;
    if (done_n != 0 || valid_n != 0 || clr_n != 0) begin
      n_err++;
      $display("FAIL rstmid_quiet: got done=%0d valid=%0d clr=%0d required 0/0/0", done_n, valid_n, clr_n);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rstmid_sb_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_width1();
    logic [2:0] q1[$];
    logic [2:0] e;
    q1.push_back(3'b111);
    @(negedge clk);
    bus1.start = 1'b1; bus1.op_a = 1'b1; bus1.op_b = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus1.op_a = 1'b0; bus1.op_b = 1'b0;
    n_cmp++;
    if (bus1.add_clr !== 1'b1 || bus1.bit_valid !== 1'b0) begin
      n_err++;
      $display("FAIL w1_clr: got add_clr=%b valid=%b required 1/0", bus1.add_clr, bus1.bit_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus1.bit_valid !== 1'b1) begin
      n_err++;
      $display("FAIL w1_valid: got %b required 1", bus1.bit_valid);
    end else begin
      e = q1.pop_front();
      if ({bus1.a, bus1.b, bus1.last_bit} !== e) begin
        n_err++;
        $display("FAIL w1_bit: got {a,b,last}=%b required %b", {bus1.a, bus1.b, bus1.last_bit}, e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus1.done, bus1.bit_valid, bus1.a, bus1.b, bus1.ready} !== 5'b10000) begin
      n_err++;
      $display("FAIL w1_done: got {done,valid,a,b,ready}=%b required 10000",
               {bus1.done, bus1.bit_valid, bus1.a, bus1.b, bus1.ready});
    end
    @(negedge clk);
    n_cmp++;
    if (bus1.ready !== 1'b1 || bus1.done !== 1'b0) begin
      n_err++;
      $display("FAIL w1_ready_back: got ready=%b done=%b required 1/0", bus1.ready, bus1.done);
    end
  endtask

  task automatic test_back_to_back();
    int clr_at[$];
    int done_at[$];
    int ready_at[$];
    push_bits(8'hFF, 8'h01, 8);
    push_bits(8'h00, 8'h00, 8);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op_a = 8'hFF; bus8.op_b = 8'h01;
    for (int cyc = 0; cyc <= 21; cyc++) begin
      @(negedge clk);
      if (bus8.add_clr === 1'b1) clr_at.push_back(cyc);
      if (bus8.done === 1'b1) done_at.push_back(cyc);
      if (bus8.ready === 1'b1) ready_at.push_back(cyc);
      if (cyc == 0) begin bus8.op_a = 8'h00; bus8.op_b = 8'h00; end
      if (clr_at.size() == 2) bus8.start = 1'b0;
    end
    bus8.start = 1'b0;
    n_cmp++;
    if (clr_at.size() != 2 || clr_at[0] != 0 || clr_at[1] != 11) begin
      n_err++;
      $display("FAIL b2b_clr: got n=%0d first=%0d second=%0d required 2/0/11", clr_at.size(),
               (clr_at.size() > 0) ? clr_at[0] : -1, (clr_at.size() > 1) ? clr_at[1] : -1);
    end
    n_cmp++;
    if (done_at.size() != 2 || done_at[0] != 9 || done_at[1] != 20) begin
      n_err++;
      $display("FAIL b2b_done: got n=%0d first=%0d second=%0d required 2/9/20", done_at.size(),
               (done_at.size() > 0) ? done_at[0] : -1, (done_at.size() > 1) ? done_at[1] : -1);
    end
    n_cmp++;
    if (ready_at.size() != 2 || ready_at[0] != 10 || ready_at[1] != 21) begin
      n_err++;
      $display("FAIL b2b_ready: got n=%0d first=%0d second=%0d required 2/10/21", ready_at.size(),
               (ready_at.size() > 0) ? ready_at[0] : -1, (ready_at.size() > 1) ? ready_at[1] : -1);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_sb_left: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid();
    test_width1();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_serializer.md
OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, operand bit count; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request to serialize one operand pair; accepted only when ready=1.
REQ-005 op_a  input  WIDTH  first addend, captured on the accepting edge.
REQ-006 op_b  input  WIDTH  second addend, captured on the accepting edge.
REQ-007 ready  output  1  high only in IDLE; block can accept start.
REQ-008 add_clr  output  1  one-cycle pulse that clears the downstream serial adder's carry state.
REQ-009 a  output  1  current bit of op_a, LSB first; drives the adder's a input.
REQ-010 b  output  1  current bit of op_b, LSB first; drives the adder's b input.
REQ-011 bit_valid  output  1  high while a/b carry a valid operand bit.
REQ-012 last_bit  output  1  high with bit_valid on the MSB (bit WIDTH-1).
REQ-013 done  output  1  one-cycle pulse after the last bit is presented.

Function
REQ-014 All outputs are registered; no combinational path from any input to any output.
REQ-015 FSM states: IDLE, CLR, SHIFT, DONE; the encoding is an implementation choice.
REQ-016 IDLE: ready=1, all other outputs 0; start=1 -> capture op_a/op_b into shift registers, go to CLR.
REQ-017 CLR: one cycle; add_clr=1, a=b=0, bit_valid=0; next state SHIFT with the bit index at 0.
REQ-018 SHIFT: a=sa[0], b=sb[0], bit_valid=1; both shift registers shift right by 1 and the index increments each cycle.
REQ-019 SHIFT lasts exactly WIDTH cycles; last_bit=1 only while the index is WIDTH-1; then the FSM goes to DONE.
REQ-020 DONE: one cycle; done=1, bit_valid=0, a=b=0, ready=0; next state IDLE.
REQ-021 Latency: start accepted at edge T -> add_clr high in cycle T+1, bits in cycles T+2..T+1+WIDTH, done in cycle T+2+WIDTH, ready high again in cycle T+3+WIDTH.
REQ-022 start when ready=0 (CLR/SHIFT/DONE) is ignored, is not queued, and does not alter the captured operands.
REQ-023 op_a/op_b changes after acceptance have no effect on the bits being serialized.
REQ-024 Index counter width is max(1, clog2(WIDTH)); WIDTH=1 gives one SHIFT cycle with bit_valid=1 and last_bit=1 together.
REQ-025 a and b outside SHIFT are 0, so the adder sees no spurious carry generation.
REQ-026 start held high continuously gives back-to-back operations with exactly one IDLE cycle between done and the next add_clr.

Reset
REQ-027 reset=1 at any edge forces IDLE, ready=1, and add_clr=a=b=bit_valid=last_bit=done=0 from the next cycle.
REQ-028 reset overrides start in the same cycle; no operation is accepted.
REQ-029 reset mid-SHIFT aborts the operation; no done pulse is issued for it, and the shift registers and index are cleared.

Verification
REQ-030 Bench case: reset 2 cycles -> ready=1, all other outputs 0.
REQ-031 Bench case: WIDTH=8, op_a=0xA5, op_b=0x3C, start 1 cycle -> add_clr 1 cycle; a=1,0,1,0,0,1,0,1 and b=0,0,1,1,1,1,0,0 over 8 bit_valid cycles; last_bit on the 8th; done in the next cycle.
REQ-032 Bench case: start pulsed and op_a/op_b changed during SHIFT -> bit stream unchanged, no second add_clr, ready stays 0 until after done.
REQ-033 Bench case: reset asserted in the 4th SHIFT cycle -> next cycle IDLE, ready=1, bit_valid=0, no done pulse.
REQ-034 Bench case: WIDTH=1, op_a=1, op_b=1 -> one SHIFT cycle with a=b=1, bit_valid=last_bit=1, done in the next cycle.
REQ-035 Bench case: start held high, ops 0xFF/0x01 then 0x00/0x00 -> two complete sequences, each preceded by add_clr, separated by exactly one ready cycle.
